// File: rtl/tof_coarse_timer_if.sv
// Handshake/result bundle between the coarse ToF timer and its SoC-side user.
// The slave modport is the timer, the master modport is the register/consumer side.
interface tof_coarse_timer_if #(
    parameter int CNT_W = 16
);
    logic             io_start;
    logic             io_trigOut;
    logic             io_stopIn;
    logic             io_busy;
    logic             io_valid;
    logic             io_ready;
    logic [CNT_W-1:0] io_count;
    logic             io_timeout;

    modport master (
        output io_start, io_stopIn, io_ready,
        input  io_trigOut, io_busy, io_valid, io_count, io_timeout
    );

    modport slave (
        input  io_start, io_stopIn, io_ready,
        output io_trigOut, io_busy, io_valid, io_count, io_timeout
    );
endinterface

// File: rtl/tof_coarse_timer.sv
// Coarse time-of-flight timer: fires a trigger pulse, counts cycles until the synchronized
// return edge or a timeout. Define TOF_GLITCH_FILTER_EN to reject single-cycle stop highs.
module tof_coarse_timer #(
    parameter int CNT_W          = 16,
    parameter int PULSE_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic               io_mainClk,
    input logic               io_reset,
    tof_coarse_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PULSE, WAIT, DONE} state_e;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_VAL    = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             timeout_q, timeout_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic             stop_edge;

`ifdef TOF_GLITCH_FILTER_EN
    // Require two consecutive synchronized highs after a low.
    logic prev2_q, prev2_d;
    assign prev2_d   = prev_q;
    assign stop_edge = sync2_q & prev_q & ~prev2_q;

    always_ff @(posedge io_mainClk) begin
        if (io_reset) prev2_q <= 1'b0;
        else          prev2_q <= prev2_d;
    end
`else
    assign stop_edge = sync2_q & ~prev_q;
`endif

    assign sync1_d = bus.io_stopIn;
    assign sync2_d = sync1_q;
    assign prev_d  = sync2_q;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (bus.io_start) begin
                    state_d   = PULSE;
                    counter_d = '0;
                end
            end
            PULSE, WAIT: begin
                counter_d = counter_q + 1'b1;
                // Stop edge takes priority over a coincident timeout.
                if (stop_edge) begin
                    state_d   = DONE;
                    count_d   = counter_q;
                    timeout_d = 1'b0;
                end else if (state_q == WAIT && counter_q == TMO_LAST) begin
                    state_d   = DONE;
                    count_d   = TMO_VAL;
                    timeout_d = 1'b1;
                end else if (state_q == PULSE && counter_q == PULSE_LAST) begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (valid_q && bus.io_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        trig_d  = (state_d == PULSE);
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
        end
    end

    assign bus.io_trigOut = trig_q;
    assign bus.io_busy    = busy_q;
    assign bus.io_valid   = valid_q;
    assign bus.io_count   = count_q;
    assign bus.io_timeout = timeout_q;
endmodule

// File: tb/tb_tof_coarse_timer.sv
// Directed bench for tof_coarse_timer (defaults CNT_W=16, PULSE_LEN=4, TIMEOUT_CYCLES=1000).
// Expected values follow TOF_GLITCH_FILTER_EN when it is defined for the build.
module tb_tof_coarse_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loop_en = 1'b0;
    logic stop_drv = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n;
    int   highs;

`ifdef TOF_GLITCH_FILTER_EN
    localparam int LOOP_CNT = 3;
    localparam int GLITCH_CNT = 53;
    localparam int LATE_LEAD = 996;
`else
    localparam int LOOP_CNT = 2;
    localparam int GLITCH_CNT = 12;
    localparam int LATE_LEAD = 997;
`endif

    tof_coarse_timer_if #(.CNT_W(16)) bus ();

    tof_coarse_timer #(.CNT_W(16), .PULSE_LEN(4), .TIMEOUT_CYCLES(1000)) dut (
        .io_mainClk (clk),
        .io_reset   (rst),
        .bus        (bus.slave)
    );

    assign bus.io_stopIn = loop_en ? bus.io_trigOut : stop_drv;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max, output int cnt);
        cnt = 0;
        while (bus.io_valid !== 1'b1 && cnt < max) begin
            tick();
            cnt++;
        end
        chk("valid_within_bound", {31'd0, bus.io_valid}, 32'd1);
    endtask

    task automatic handshake();
        bus.io_ready = 1'b1;
        tick();
        bus.io_ready = 1'b0;
        chk("hs_valid_low", {31'd0, bus.io_valid}, 32'd0);
        chk("hs_busy_low", {31'd0, bus.io_busy}, 32'd0);
    endtask

    task automatic start_meas();
        bus.io_start = 1'b1;
        tick();
        bus.io_start = 1'b0;
    endtask

    initial begin
        bus.io_start = 1'b0;
        bus.io_ready = 1'b0;
        repeat (2) tick();
        chk("rst_trig", {31'd0, bus.io_trigOut}, 32'd0);
        chk("rst_busy", {31'd0, bus.io_busy}, 32'd0);
        chk("rst_valid", {31'd0, bus.io_valid}, 32'd0);
        chk("rst_count", {16'd0, bus.io_count}, 32'd0);
        chk("rst_timeout", {31'd0, bus.io_timeout}, 32'd0);
        rst = 1'b0;
        tick();

        // Loopback: trigger feeds straight back as the stop input.
        loop_en = 1'b1;
        start_meas();
        chk("loop_trig_first", {31'd0, bus.io_trigOut}, 32'd1);
        chk("loop_busy", {31'd0, bus.io_busy}, 32'd1);
        wait_valid(50, n);
        chk("loop_count", {16'd0, bus.io_count}, LOOP_CNT);
        chk("loop_timeout", {31'd0, bus.io_timeout}, 32'd0);
        chk("loop_trig_cut", {31'd0, bus.io_trigOut}, 32'd0);
        handshake();
        loop_en = 1'b0;
        repeat (4) tick();

        // Stop held low: full timeout, and trigger width measured along the way.
        start_meas();
        highs = 0;
        n = 0;
        while (bus.io_valid !== 1'b1 && n < 1100) begin
            highs += int'(bus.io_trigOut);
            tick();
            n++;
        end
        chk("tmo_cycles", n, 32'd1000);
        chk("tmo_pulse_len", highs, 32'd4);
        chk("tmo_count", {16'd0, bus.io_count}, 32'd1000);
        chk("tmo_flag", {31'd0, bus.io_timeout}, 32'd1);
        handshake();

        // One-cycle glitch in cycle 10, real rise in cycle 50.
        start_meas();
        repeat (10) tick();
        stop_drv = 1'b1;
        tick();
        stop_drv = 1'b0;
        repeat (39) tick();
        stop_drv = 1'b1;
        wait_valid(100, n);
        chk("glitch_count", {16'd0, bus.io_count}, GLITCH_CNT);
        chk("glitch_timeout", {31'd0, bus.io_timeout}, 32'd0);

        // Consumer stalls in DONE while start is pulsed.
        for (int i = 0; i < 20; i++) begin
            bus.io_start = (i == 5);
            tick();
            chk("stall_valid", {31'd0, bus.io_valid}, 32'd1);
            chk("stall_count", {16'd0, bus.io_count}, GLITCH_CNT);
            chk("stall_trig", {31'd0, bus.io_trigOut}, 32'd0);
        end
        bus.io_start = 1'b0;
        handshake();
        chk("hs_no_trig", {31'd0, bus.io_trigOut}, 32'd0);

        // Immediate restart with stop still high: no edge, so it must time out.
        start_meas();
        chk("restart_trig", {31'd0, bus.io_trigOut}, 32'd1);
        chk("restart_busy", {31'd0, bus.io_busy}, 32'd1);
        wait_valid(1100, n);
        chk("high_stop_timeout", {31'd0, bus.io_timeout}, 32'd1);
        chk("high_stop_count", {16'd0, bus.io_count}, 32'd1000);
        stop_drv = 1'b0;
        handshake();
        repeat (4) tick();

        // Reset in cycle 2 of the trigger pulse.
        start_meas();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_trig", {31'd0, bus.io_trigOut}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.io_busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.io_valid}, 32'd0);
        chk("mid_rst_count", {16'd0, bus.io_count}, 32'd0);
        rst = 1'b0;
        repeat (8) tick();
        chk("post_rst_valid", {31'd0, bus.io_valid}, 32'd0);

        // Stop edge lands in the last counted cycle: stop wins over timeout.
        start_meas();
        repeat (LATE_LEAD) tick();
        stop_drv = 1'b1;
        wait_valid(20, n);
        chk("late_count", {16'd0, bus.io_count}, 32'd999);
        chk("late_timeout", {31'd0, bus.io_timeout}, 32'd0);
        stop_drv = 1'b0;
        handshake();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tof_coarse_timer.md
TOF_COARSE_TIMER -- requirements
Module: tof_coarse_timer

Interface
REQ-001 The parameter CNT_W SHALL default to 16 and set the measurement counter width.
REQ-002 The parameter PULSE_LEN SHALL default to 4 and set the trigger pulse width in cycles (legal range 1..255).
REQ-003 The parameter TIMEOUT_CYCLES SHALL default to 1000 and set the measurement window (legal range PULSE_LEN+1 .. 2^CNT_W-1).
REQ-004 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-005 io_mainClk  in  1  sole clock; all state changes on its rising edge.
REQ-006 io_reset  in  1  synchronous, active-high reset.
REQ-007 io_start  in  1  measurement request from the SoC register; sampled only in IDLE.
REQ-008 io_trigOut  out  1  registered laser/trigger pulse to the trigsOut0 pin.
REQ-009 io_stopIn  in  1  asynchronous return-pulse input from the trigsIn pin.
REQ-010 io_busy  out  1  high whenever the state is not IDLE.
REQ-011 io_valid  out  1  result available.
REQ-012 io_ready  in  1  consumer accepts the result.
REQ-013 io_count  out  CNT_W  measured cycle count; valid while io_valid is high.
REQ-014 io_timeout  out  1  result was a timeout; valid while io_valid is high.

Function
REQ-015 io_stopIn SHALL pass through a 2-flop synchronizer (sync1, sync2), plus a history register prev = sync2 delayed by one cycle, regardless of state.
REQ-016 A stop edge SHALL be sync2 & ~prev, evaluated combinationally in the current cycle.
REQ-017 The FSM SHALL have four states, IDLE, PULSE, WAIT and DONE, with IDLE as the reset state.
REQ-018 IDLE: io_start=1 SHALL move the FSM to PULSE and load counter=0; io_start pulses or levels seen outside IDLE are ignored.
REQ-019 PULSE: io_trigOut SHALL be high for exactly PULSE_LEN cycles, beginning in the first PULSE cycle; the FSM then enters WAIT.
REQ-020 counter SHALL be 0 in the first PULSE cycle and increment by 1 every cycle in PULSE and WAIT.
REQ-021 A stop edge in PULSE or WAIT SHALL move the FSM to DONE, capture io_count=counter and set io_timeout=0.
REQ-022 WAIT with counter==TIMEOUT_CYCLES-1 and no stop edge SHALL move the FSM to DONE with io_count=TIMEOUT_CYCLES and io_timeout=1.
REQ-023 If a stop edge and the timeout occur in the same cycle, the stop edge SHALL win.
REQ-024 If io_stopIn is already high at start, it SHALL NOT produce a stop edge; it must fall and rise again.
REQ-025 DONE: io_valid=1 and io_count/io_timeout SHALL hold stable until io_valid&io_ready, after which the FSM returns to IDLE next cycle.
REQ-026 The fastest restart SHALL be io_start accepted in the first IDLE cycle after the handshake.
REQ-027 The counter SHALL never wrap, because it is bounded by TIMEOUT_CYCLES.

Reset
REQ-028 io_reset=1 SHALL force, at the next edge: state=IDLE, counter=0, io_trigOut=0, io_valid=0, io_busy=0, io_count=0, io_timeout=0, sync1=sync2=prev=0.
REQ-029 A reset asserted mid-measurement SHALL discard the result and end any trigger pulse immediately.

Configuration
REQ-030 The macro TOF_GLITCH_FILTER_EN SHALL select the stop-edge qualifier.
REQ-031 With TOF_GLITCH_FILTER_EN defined, a stop edge SHALL require sync2 high for 2 consecutive cycles after a low (an extra register prev2; edge = sync2 & prev & ~prev2), so detection is 1 cycle later and single-cycle highs are rejected.
REQ-032 With TOF_GLITCH_FILTER_EN undefined, REQ-016 SHALL apply unchanged.

Verification
REQ-033 Loopback io_stopIn=io_trigOut, PULSE_LEN=4 -> io_count=2, io_timeout=0 (3 with TOF_GLITCH_FILTER_EN).
REQ-034 io_stopIn tied low, TIMEOUT_CYCLES=1000 -> io_valid after 1000 cycles in PULSE/WAIT, io_count=1000, io_timeout=1.
REQ-035 1-cycle io_stopIn glitch at cycle 10, real rise at cycle 50 -> without filter io_count=12; with filter io_count=53.
REQ-036 io_ready held low for 20 cycles in DONE, with io_start pulsed -> io_count stable, io_valid high, no new pulse; io_ready=1 -> IDLE next cycle.
REQ-037 io_reset at cycle 2 of PULSE -> io_trigOut=0 and io_busy=0 after the next edge, no io_valid.
REQ-038 Stop edge in the cycle counter==TIMEOUT_CYCLES-1 -> io_count=TIMEOUT_CYCLES-1, io_timeout=0.
